reel_spin_ctrl: RTL and testbench

- Sequences the three slot reels after a spin command from the MCU arrives over SPI.
- Latches the three target symbol indices and steps all reels at a fixed rate. Stops reel 1, then reel 2, then reel 3 on their targets after minimum spin and stagger distances.
- Reports completion so the credit/win display path can proceed.
- Sits between the SPI command decoder (start_spin, reelN_idx) and the reel display/renderer.

---
 rtl/reel_spin_ctrl.sv | 172 +++++++++++++++++
 tb/tb_reel_spin_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reel_spin_ctrl.sv
// Three-reel spin sequencer: accepts a spin request, steps the reels at a fixed
// tick rate and stops reel 1, 2, 3 in order on their latched targets.
module reel_spin_ctrl #(
    parameter int NUM_SYMBOLS = 10,
    parameter int STEP_DIV    = 4,
    parameter int MIN_STEPS   = 20,
    parameter int STAGGER     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_spin,
    input  logic [3:0] target1,
    input  logic [3:0] target2,
    input  logic [3:0] target3,
    output logic [3:0] reel1_pos,
    output logic [3:0] reel2_pos,
    output logic [3:0] reel3_pos,
    output logic [2:0] reel_moving,
    output logic       busy,
    output logic       spin_done,
    output logic       overrun,
    output logic       bad_target
);

    localparam int               DIV_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [3:0]       POS_LAST = 4'(NUM_SYMBOLS - 1);
    localparam logic [7:0]       MIN_T    = 8'(MIN_STEPS);
    localparam logic [7:0]       STAG_T   = 8'(STAGGER);

    typedef enum logic [2:0] {IDLE, SPIN3, SPIN2, SPIN1, DONE} state_t;

    state_t           state, state_nxt;
    logic             start_q;
    logic [DIV_W-1:0] divider, divider_nxt;
    logic [7:0]       tick_cnt, tick_cnt_nxt;
    logic [7:0]       stop_tick, stop_tick_nxt;
    logic [3:0]       tgt1, tgt2, tgt3, tgt1_nxt, tgt2_nxt, tgt3_nxt;
    logic [3:0]       pos1_nxt, pos2_nxt, pos3_nxt;
    logic [2:0]       moving_nxt;
    logic             busy_nxt, done_nxt, overrun_nxt, bad_nxt;

    logic             req, tick;
    logic [7:0]       tick_inc, since_stop;
    logic [3:0]       inc1, inc2, inc3;

    function automatic logic [3:0] next_pos(input logic [3:0] p);
        return (p == POS_LAST) ? 4'd0 : p + 4'd1;
    endfunction

    function automatic logic is_bad(input logic [3:0] t);
        return (int'(t) >= NUM_SYMBOLS);
    endfunction

    // Stop tests look at the post-increment position of the same tick.
    always_comb begin
        req        = start_spin & ~start_q;
        tick       = (divider == DIV_LAST);
        tick_inc   = (tick_cnt == 8'hFF) ? tick_cnt : tick_cnt + 8'd1;
        since_stop = tick_inc - stop_tick;
        inc1       = next_pos(reel1_pos);
        inc2       = next_pos(reel2_pos);
        inc3       = next_pos(reel3_pos);

        state_nxt     = state;
        divider_nxt   = divider;
        tick_cnt_nxt  = tick_cnt;
        stop_tick_nxt = stop_tick;
        tgt1_nxt      = tgt1;
        tgt2_nxt      = tgt2;
        tgt3_nxt      = tgt3;
        pos1_nxt      = reel1_pos;
        pos2_nxt      = reel2_pos;
        pos3_nxt      = reel3_pos;
        moving_nxt    = reel_moving;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        overrun_nxt   = overrun;
        bad_nxt       = bad_target;

        case (state)
            IDLE: begin
                if (req) begin
                    tgt1_nxt      = is_bad(target1) ? 4'd0 : target1;
                    tgt2_nxt      = is_bad(target2) ? 4'd0 : target2;
                    tgt3_nxt      = is_bad(target3) ? 4'd0 : target3;
                    bad_nxt       = bad_target | is_bad(target1) | is_bad(target2) | is_bad(target3);
                    overrun_nxt   = 1'b0;
                    busy_nxt      = 1'b1;
                    moving_nxt    = 3'b111;
                    divider_nxt   = '0;
                    tick_cnt_nxt  = 8'd0;
                    stop_tick_nxt = 8'd0;
                    state_nxt     = SPIN3;
                end
            end
            SPIN3, SPIN2, SPIN1: begin
                if (req) overrun_nxt = 1'b1;
                divider_nxt = tick ? '0 : divider + 1'b1;
                if (tick) begin
                    tick_cnt_nxt = tick_inc;
                    if (reel_moving[0]) pos1_nxt = inc1;
                    if (reel_moving[1]) pos2_nxt = inc2;
                    if (reel_moving[2]) pos3_nxt = inc3;
                    case (state)
                        SPIN3: if (tick_inc >= MIN_T && inc1 == tgt1) begin
                            moving_nxt[0] = 1'b0;
                            stop_tick_nxt = tick_inc;
                            state_nxt     = SPIN2;
                        end
                        SPIN2: if (since_stop >= STAG_T && inc2 == tgt2) begin
                            moving_nxt[1] = 1'b0;
                            stop_tick_nxt = tick_inc;
                            state_nxt     = SPIN1;
                        end
                        SPIN1: if (since_stop >= STAG_T && inc3 == tgt3) begin
                            moving_nxt[2] = 1'b0;
                            state_nxt     = DONE;
                        end
                        default: ;
                    endcase
                end
            end
            DONE: begin
                if (req) overrun_nxt = 1'b1;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            divider     <= '0;
            tick_cnt    <= 8'd0;
            stop_tick   <= 8'd0;
            tgt1        <= 4'd0;
            tgt2        <= 4'd0;
            tgt3        <= 4'd0;
            reel1_pos   <= 4'd0;
            reel2_pos   <= 4'd0;
            reel3_pos   <= 4'd0;
            reel_moving <= 3'b000;
            busy        <= 1'b0;
            spin_done   <= 1'b0;
            overrun     <= 1'b0;
            bad_target  <= 1'b0;
        end else begin
            state       <= state_nxt;
            start_q     <= start_spin;
            divider     <= divider_nxt;
            tick_cnt    <= tick_cnt_nxt;
            stop_tick   <= stop_tick_nxt;
            tgt1        <= tgt1_nxt;
            tgt2        <= tgt2_nxt;
            tgt3        <= tgt3_nxt;
            reel1_pos   <= pos1_nxt;
            reel2_pos   <= pos2_nxt;
            reel3_pos   <= pos3_nxt;
            reel_moving <= moving_nxt;
            busy        <= busy_nxt;
            spin_done   <= done_nxt;
            overrun     <= overrun_nxt;
            bad_target  <= bad_nxt;
        end
    end

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Bench for reel_spin_ctrl: directed and random spins compared against a model
// that derives stop ticks arithmetically from start positions and targets.
module tb_reel_spin_ctrl;

    localparam int NS   = 10;
    localparam int SD   = 4;
    localparam int MINS = 20;
    localparam int STAG = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_spin;
    logic [3:0] target1, target2, target3;
    logic [3:0] reel1_pos, reel2_pos, reel3_pos;
    logic [2:0] reel_moving;
    logic       busy, spin_done, overrun, bad_target;

    int checks = 0;
    int errors = 0;
    int mpos[3];
    bit badExp = 1'b0;

    reel_spin_ctrl #(
        .NUM_SYMBOLS(NS), .STEP_DIV(SD), .MIN_STEPS(MINS), .STAGGER(STAG)
    ) dut (
        .clk(clk), .reset(reset), .start_spin(start_spin),
        .target1(target1), .target2(target2), .target3(target3),
        .reel1_pos(reel1_pos), .reel2_pos(reel2_pos), .reel3_pos(reel3_pos),
        .reel_moving(reel_moving), .busy(busy), .spin_done(spin_done),
        .overrun(overrun), .bad_target(bad_target)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Smallest tick n >= from at which a reel starting at p shows tg.
    function automatic int firstHit(input int p, input int tg, input int from);
        for (int n = from; n < from + NS; n++)
            if ((p + n) % NS == tg) return n;
        return from;
    endfunction

    task automatic checkResetState();
        checkOutput("rst_pos1", reel1_pos, 0);
        checkOutput("rst_pos2", reel2_pos, 0);
        checkOutput("rst_pos3", reel3_pos, 0);
        checkOutput("rst_moving", reel_moving, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", spin_done, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_bad", bad_target, 0);
    endtask

    task automatic applyStimulus(input int a, input int b, input int c);
        @(negedge clk);
        start_spin = 1'b0;
        target1 = 4'(a);
        target2 = 4'(b);
        target3 = 4'(c);
        @(negedge clk);
        start_spin = 1'b1;
    endtask

    // m counts negedges after the accepting posedge; tick k lands at m = SD*k.
    task automatic watchSpin(input int a, input int b, input int c,
                             input bit doOv, input int abortM);
        int tg[3];
        int st[3];
        int t[3];
        int p0[3];
        int tk;
        tg = '{a, b, c};
        for (int i = 0; i < 3; i++) begin
            st[i] = (tg[i] >= NS) ? 0 : tg[i];
            if (tg[i] >= NS) badExp = 1'b1;
            p0[i] = mpos[i];
        end
        t[0] = firstHit(p0[0], st[0], MINS);
        t[1] = firstHit(p0[1], st[1], t[0] + STAG);
        t[2] = firstHit(p0[2], st[2], t[1] + STAG);
        for (int m = 0; m <= SD * t[2] + 3; m++) begin
            @(negedge clk);
            if (m == abortM) begin
                reset = 1'b1;
                #1;
                checkResetState();
                for (int i = 0; i < 3; i++) mpos[i] = 0;
                badExp = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    checkOutput("rst_no_done", spin_done, 0);
                end
                return;
            end
            tk = m / SD;
            checkOutput("pos1", reel1_pos, (p0[0] + ((tk < t[0]) ? tk : t[0])) % NS);
            checkOutput("pos2", reel2_pos, (p0[1] + ((tk < t[1]) ? tk : t[1])) % NS);
            checkOutput("pos3", reel3_pos, (p0[2] + ((tk < t[2]) ? tk : t[2])) % NS);
            checkOutput("moving", reel_moving,
                        ((m < SD * t[2]) ? 4 : 0) + ((m < SD * t[1]) ? 2 : 0) + ((m < SD * t[0]) ? 1 : 0));
            checkOutput("busy", busy, (m <= SD * t[2]) ? 1 : 0);
            checkOutput("spin_done", spin_done, (m == SD * t[2] + 1) ? 1 : 0);
            checkOutput("overrun", overrun, (doOv && m >= 20) ? 1 : 0);
            checkOutput("bad_target", bad_target, badExp ? 1 : 0);
            if (doOv && m == 18) start_spin = 1'b0;
            if (doOv && m == 19) start_spin = 1'b1;
        end
        for (int i = 0; i < 3; i++) mpos[i] = st[i];
        checkOutput("final1", reel1_pos, st[0]);
        checkOutput("final2", reel2_pos, st[1]);
        checkOutput("final3", reel3_pos, st[2]);
    endtask

    task automatic holdIdle(input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_done", spin_done, 0);
            checkOutput("idle_moving", reel_moving, 0);
        end
    endtask

    initial begin
        int a, b, c;
        reset = 1'b1;
        start_spin = 1'b0;
        target1 = 4'd0;
        target2 = 4'd0;
        target3 = 4'd0;
        repeat (3) @(negedge clk);
        checkResetState();
        reset = 1'b0;

        $display("[TB] first spin 3/7/7 from 0/0/0");
        applyStimulus(3, 7, 7);
        watchSpin(3, 7, 7, 1'b0, -1);
        holdIdle(40);

        $display("[TB] second spin 3/7/7 from 3/7/7");
        applyStimulus(3, 7, 7);
        watchSpin(3, 7, 7, 1'b0, -1);

        $display("[TB] overrun during spin");
        a = $urandom_range(0, NS - 1);
        b = $urandom_range(0, NS - 1);
        c = $urandom_range(0, NS - 1);
        applyStimulus(a, b, c);
        watchSpin(a, b, c, 1'b1, -1);
        holdIdle(30);

        $display("[TB] out-of-range target1");
        b = $urandom_range(0, NS - 1);
        c = $urandom_range(0, NS - 1);
        applyStimulus(12, b, c);
        watchSpin(12, b, c, 1'b0, -1);

        $display("[TB] reset mid-spin at tick 15");
        a = $urandom_range(0, NS - 1);
        b = $urandom_range(0, NS - 1);
        c = $urandom_range(0, NS - 1);
        applyStimulus(a, b, c);
        watchSpin(a, b, c, 1'b0, 60);
        a = $urandom_range(0, NS - 1);
        b = $urandom_range(0, NS - 1);
        c = $urandom_range(0, NS - 1);
        target1 = 4'(a);
        target2 = 4'(b);
        target3 = 4'(c);
        reset = 1'b0;
        watchSpin(a, b, c, 1'b0, -1);
        holdIdle(20);

        $display("[TB] random spins");
        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            c = $urandom_range(0, 15);
            applyStimulus(a, b, c);
            watchSpin(a, b, c, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
